// File: rtl/nbit_serial_sub.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining SUB_OVERFLOW_FLAG_EN.
module nbit_serial_sub #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] diff,
`ifdef SUB_OVERFLOW_FLAG_EN
    output logic         ovf,
`endif
    output logic         b_out
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [n-1:0]   a_sh_r;
    logic [n-1:0]   b_sh_r;
    logic [n-1:0]   acc_r;
    logic           borrow_r;
    logic [CW-1:0]  count_r;
    logic           d_s;
    logic           borrow_next_s;
    logic [n-1:0]   acc_next_s;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic           a_msb_r;
    logic           b_msb_r;
`endif

    // Full-subtractor cell on the current LSBs; new bit enters the accumulator MSB.
    always_comb begin
        d_s           = a_sh_r[0] ^ b_sh_r[0] ^ borrow_r;
        borrow_next_s = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & borrow_r);
        acc_next_s    = {d_s, acc_r[n-1:1]};
    end

    // Control FSM, operand shifters and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sh_r   <= {n{1'b0}};
            b_sh_r   <= {n{1'b0}};
            acc_r    <= {n{1'b0}};
            borrow_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= {n{1'b0}};
            b_out    <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= b_in;
                        acc_r    <= {n{1'b0}};
                        count_r  <= {CW{1'b0}};
                        busy     <= 1'b1;
                        state_r  <= RUN;
`ifdef SUB_OVERFLOW_FLAG_EN
                        a_msb_r  <= a[n-1];
                        b_msb_r  <= b[n-1];
`endif
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[n-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[n-1:1]};
                    acc_r    <= acc_next_s;
                    borrow_r <= borrow_next_s;
                    count_r  <= count_r + CW'(1'b1);
                    // Last bit: publish the finished accumulator, not the stale acc_r.
                    if (count_r == LAST) begin
                        diff    <= acc_next_s;
                        b_out   <= borrow_next_s;
                        done    <= 1'b1;
                        state_r <= DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
                        ovf     <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
                    end else begin
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nbit_serial_sub.sv
// Directed and random self-checking bench for nbit_serial_sub with n = 8.
module tb_nbit_serial_sub;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = 8'h00;
    logic [N-1:0] b = 8'h00;
    logic         b_in = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         b_out;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail = 0;

    nbit_serial_sub #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SUB_OVERFLOW_FLAG_EN
        .ovf   (ovf),
`endif
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    // Launch one operation from IDLE; lat counts edges from the accepting edge to
    // the edge raising done, both inclusive (0 on timeout).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          output int lat, output int busy_cyc, output int pulses);
        @(negedge clk);
        a = ta; b = tb; b_in = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; pulses = 0;
        busy_cyc = busy ? 1 : 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (done) begin
                pulses++;
                if (lat == 0) lat = i + 1;
            end else if (lat != 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
        end
        n_checks++;
        if (diff !== 8'h00 || b_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: diff=%h b_out=%b required 00 0", diff, b_out);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc, pc;
        run_op(8'h05, 8'h03, 1'b0, lat, bc, pc);
        n_checks++;
        if (lat !== N + 1) begin
            n_fail++; $display("FAIL latency: got %0d required %0d", lat, N + 1);
        end
        n_checks++;
        if (bc !== N + 1) begin
            n_fail++; $display("FAIL busy_len: got %0d required %0d", bc, N + 1);
        end
        n_checks++;
        if (pc !== 1) begin
            n_fail++; $display("FAIL done_pulse: got %0d required 1", pc);
        end
        n_checks++;
        if (diff !== 8'h02 || b_out !== 1'b0) begin
            n_fail++; $display("FAIL sub_5_3: diff=%h b_out=%b required 02 0", diff, b_out);
        end
        run_op(8'h03, 8'h05, 1'b0, lat, bc, pc);
        n_checks++;
        if (diff !== 8'hFE || b_out !== 1'b1) begin
            n_fail++; $display("FAIL sub_3_5: diff=%h b_out=%b required fe 1", diff, b_out);
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_3_5: got %b required 0", ovf);
        end
`endif
        run_op(8'h00, 8'h00, 1'b1, lat, bc, pc);
        n_checks++;
        if (diff !== 8'hFF || b_out !== 1'b1) begin
            n_fail++; $display("FAIL sub_0_0_bin: diff=%h b_out=%b required ff 1", diff, b_out);
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_0_0: got %b required 0", ovf);
        end
`endif
    endtask

    task automatic test_ovf();
        int lat, bc, pc;
        run_op(8'h80, 8'h01, 1'b0, lat, bc, pc);
        n_checks++;
        if (diff !== 8'h7F || b_out !== 1'b0) begin
            n_fail++; $display("FAIL sub_80_01: diff=%h b_out=%b required 7f 0", diff, b_out);
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_80_01: got %b required 1", ovf);
        end
`endif
        run_op(8'h7F, 8'hFF, 1'b0, lat, bc, pc);
        n_checks++;
        if (diff !== 8'h80 || b_out !== 1'b1) begin
            n_fail++; $display("FAIL sub_7f_ff: diff=%h b_out=%b required 80 1", diff, b_out);
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_7f_ff: got %b required 1", ovf);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        @(negedge clk);
        a = 8'hAA; b = 8'h55; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL ignore_pulses: got %0d required 1", pulses);
        end
        n_checks++;
        if (diff !== 8'h55 || b_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_result: diff=%h b_out=%b busy=%b required 55 0 0", diff, b_out, busy);
        end
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        int lat, bc, pc;
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset: busy=%b done=%b diff=%h required 0 0 00", busy, done, diff);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL reset_no_done: got %0d pulses required 0", pulses);
        end
        run_op(8'h10, 8'h01, 1'b0, lat, bc, pc);
        n_checks++;
        if (diff !== 8'h0F || b_out !== 1'b0) begin
            n_fail++; $display("FAIL after_reset: diff=%h b_out=%b required 0f 0", diff, b_out);
        end
    endtask

    task automatic test_back_to_back();
        int times[$];
        @(negedge clk);
        a = 8'h09; b = 8'h04; b_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                times.push_back(i);
                n_checks++;
                if (diff !== 8'h05 || b_out !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_result: diff=%h b_out=%b required 05 0", diff, b_out);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (times.size() < 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d dones required >=3", times.size());
        end else begin
            for (int k = 1; k < times.size(); k++) begin
                n_checks++;
                if (times[k] - times[k-1] !== N + 2) begin
                    n_fail++; $display("FAIL b2b_period: got %0d required %0d", times[k] - times[k-1], N + 2);
                end
            end
        end
        repeat (12) @(posedge clk);
    endtask

    task automatic test_random();
        int lat, bc, pc;
        logic [7:0] ta, tb;
        logic       tbin;
        logic [8:0] exp9;
        for (int k = 0; k < 1000; k++) begin
            ta = 8'($urandom_range(255, 0));
            tb = 8'($urandom_range(255, 0));
            tbin = 1'($urandom_range(1, 0));
            exp9 = {1'b0, ta} - {1'b0, tb} - {8'h00, tbin};
            run_op(ta, tb, tbin, lat, bc, pc);
            n_checks++;
            if (diff !== exp9[7:0] || b_out !== exp9[8] || lat !== N + 1) begin
                n_fail++;
                $display("FAIL random: %h-%h-%b diff=%h b_out=%b lat=%0d required %h %b %0d",
                         ta, tb, tbin, diff, b_out, lat, exp9[7:0], exp9[8], N + 1);
            end
`ifdef SUB_OVERFLOW_FLAG_EN
            n_checks++;
            if (ovf !== ((ta[7] != tb[7]) && (exp9[7] != ta[7]))) begin
                n_fail++; $display("FAIL random_ovf: %h-%h-%b got %b", ta, tb, tbin, ovf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
